// File: rtl/jedro_1_mem_pkg.sv
// -----------------------------------------------------------------------------
// jedro_1_mem_pkg
// Shared types and helpers for the jedro_1 unified-memory arbiter.
//   owner_e      : who owns the RAM response that returns next cycle
//   BURST_CNT_W  : width of the LSU burst counter (MAX_LSU_BURST <= 15)
//   word_addr()  : byte address -> word address (drops the 2 byte-offset bits)
// -----------------------------------------------------------------------------
package jedro_1_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_IFU    = 2'd1,
      OWN_LSU_RD = 2'd2,
      OWN_LSU_WR = 2'd3
   } owner_e;

   localparam int unsigned BURST_CNT_W    = 4;
   localparam int unsigned MAX_ADDR_WIDTH = 64;

   // Callers cast the result down to the RAM word-address width.
   function automatic logic [MAX_ADDR_WIDTH-1:0] word_addr(
      input logic [MAX_ADDR_WIDTH-1:0] byte_addr
   );
      return byte_addr >> 2;
   endfunction

endpackage

// File: rtl/jedro_1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// jedro_1_mem_arbiter
// Shares one single-port byte-writable synchronous RAM between the jedro_1
// instruction fetch port (IFU) and the load/store port (LSU).
//
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   ifu_req_i/addr_i              fetch request and byte address
//   ifu_gnt_o                     fetch accepted this cycle
//   ifu_rvalid_o/rdata_o          fetch data, one cycle after grant
//   lsu_req_i/we_i/be_i/addr_i/wdata_i   data request and payload
//   lsu_gnt_o                     data request accepted this cycle
//   lsu_rvalid_o/rdata_o          read data or write ack, one cycle after grant
//   ram_en_o/we_o/addr_o/wdata_o  RAM command
//   ram_rdata_i                   RAM read data, valid one cycle after ram_en_o
//
// Handshake: a requester raises req with its payload and holds both until it
// sees gnt in the same cycle; gnt is combinational and nothing is latched for
// an ungranted request. Every grant produces exactly one rvalid pulse on the
// granted port in the following cycle (writes get an ack with rdata = 0).
// rdata outputs are 0 whenever their rvalid is 0.
// -----------------------------------------------------------------------------
module jedro_1_mem_arbiter
   import jedro_1_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned RAM_ADDR_WIDTH = 10,
   parameter int unsigned MAX_LSU_BURST  = 4
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      ifu_req_i,
   input  logic [ADDR_WIDTH-1:0]     ifu_addr_i,
   output logic                      ifu_gnt_o,
   output logic                      ifu_rvalid_o,
   output logic [DATA_WIDTH-1:0]     ifu_rdata_o,
   input  logic                      lsu_req_i,
   input  logic                      lsu_we_i,
   input  logic [DATA_WIDTH/8-1:0]   lsu_be_i,
   input  logic [ADDR_WIDTH-1:0]     lsu_addr_i,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
   output logic                      lsu_gnt_o,
   output logic                      lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0]     lsu_rdata_o,
   output logic                      ram_en_o,
   output logic [DATA_WIDTH/8-1:0]   ram_we_o,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0]     ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

   localparam logic [BURST_CNT_W-1:0] MAX_BURST = BURST_CNT_W'(MAX_LSU_BURST);

   owner_e                 owner_q, owner_d;
   logic [BURST_CNT_W-1:0] burst_q, burst_d;
   logic                   ifu_win, lsu_win;

   // Grant decision. LSU has priority unless the IFU has already waited
   // through MAX_LSU_BURST consecutive LSU grants. Grants are masked while
   // in reset so every output reads 0 during reset regardless of requests.
   always_comb begin
      ifu_win = 1'b0;
      lsu_win = 1'b0;
      if (rstn_i) begin
         if (ifu_req_i && (!lsu_req_i || (burst_q == MAX_BURST))) begin
            ifu_win = 1'b1;
         end else if (lsu_req_i) begin
            lsu_win = 1'b1;
         end
      end
   end

   assign ifu_gnt_o = ifu_win;
   assign lsu_gnt_o = lsu_win;

   // RAM command, same cycle as grant.
   always_comb begin
      ram_en_o    = ifu_win | lsu_win;
      ram_we_o    = '0;
      ram_wdata_o = '0;
      ram_addr_o  = '0;
      if (lsu_win) begin
         ram_addr_o  = RAM_ADDR_WIDTH'(word_addr(MAX_ADDR_WIDTH'(lsu_addr_i)));
         ram_wdata_o = lsu_wdata_i;
         if (lsu_we_i) begin
            ram_we_o = lsu_be_i;
         end
      end else if (ifu_win) begin
         ram_addr_o  = RAM_ADDR_WIDTH'(word_addr(MAX_ADDR_WIDTH'(ifu_addr_i)));
      end
   end

   // Next owner and saturating burst counter. The counter only measures LSU
   // grants that actually kept a waiting IFU out.
   always_comb begin
      owner_d = OWN_NONE;
      if (ifu_win) begin
         owner_d = OWN_IFU;
      end else if (lsu_win) begin
         owner_d = lsu_we_i ? OWN_LSU_WR : OWN_LSU_RD;
      end

      burst_d = burst_q;
      if (!ifu_req_i || ifu_win) begin
         burst_d = '0;
      end else if (lsu_win && (burst_q < MAX_BURST)) begin
         burst_d = burst_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         owner_q <= OWN_NONE;
         burst_q <= '0;
      end else begin
         owner_q <= owner_d;
         burst_q <= burst_d;
      end
   end

   // Response routing, one cycle after grant.
   always_comb begin
      ifu_rvalid_o = 1'b0;
      ifu_rdata_o  = '0;
      lsu_rvalid_o = 1'b0;
      lsu_rdata_o  = '0;
      unique case (owner_q)
         OWN_IFU: begin
            ifu_rvalid_o = 1'b1;
            ifu_rdata_o  = ram_rdata_i;
         end
         OWN_LSU_RD: begin
            lsu_rvalid_o = 1'b1;
            lsu_rdata_o  = ram_rdata_i;
         end
         OWN_LSU_WR: begin
            lsu_rvalid_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_mem_arbiter
// Directed bench for jedro_1_mem_arbiter with a write-first byte-writable RAM
// model. The driver checks grants and RAM commands in the grant cycle and
// pushes the hand-computed response onto a per-port expected queue; a
// separate monitor pops and compares whenever a response is due.
// -----------------------------------------------------------------------------
module tb_jedro_1_mem_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int RAW  = 10;
   localparam int MAXB = 4;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rstn_i;
   always #5 clk_i = ~clk_i;

   logic            ifu_req_i;
   logic [AW-1:0]   ifu_addr_i;
   logic            ifu_gnt_o, ifu_rvalid_o;
   logic [DW-1:0]   ifu_rdata_o;
   logic            lsu_req_i, lsu_we_i;
   logic [DW/8-1:0] lsu_be_i;
   logic [AW-1:0]   lsu_addr_i;
   logic [DW-1:0]   lsu_wdata_i;
   logic            lsu_gnt_o, lsu_rvalid_o;
   logic [DW-1:0]   lsu_rdata_o;
   logic            ram_en_o;
   logic [DW/8-1:0] ram_we_o;
   logic [RAW-1:0]  ram_addr_o;
   logic [DW-1:0]   ram_wdata_o;
   logic [DW-1:0]   ram_rdata_i;

   jedro_1_mem_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW), .MAX_LSU_BURST(MAXB)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
      .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
      .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   // ---------------- RAM model (write-first, byte lanes) ----------------
   logic [DW-1:0] mem [0:(1<<RAW)-1];

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [DW/8-1:0] we);
      logic [DW-1:0] r;
      r = old_w;
      for (int b = 0; b < DW/8; b++) if (we[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      return r;
   endfunction

   initial begin
      for (int i = 0; i < (1<<RAW); i++) mem[i] <= '0;
      mem[2]      <= 32'h0050_0093;
      mem[8]      <= 32'h1234_5678;
      ram_rdata_i <= '0;
   end

   always @(posedge clk_i) begin
      if (ram_en_o) begin
         mem[ram_addr_o] <= merge(mem[ram_addr_o], ram_wdata_o, ram_we_o);
         ram_rdata_i     <= merge(mem[ram_addr_o], ram_wdata_o, ram_we_o);
      end
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] ifu_exp_q[$];
   logic [DW-1:0] lsu_exp_q[$];
   logic [DW-1:0] mon_e;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Responses are due one cycle after the grant; sampling 3 time units after
   // the edge sees the pushes made at the previous falling edge.
   always @(posedge clk_i) begin
      #3;
      if (!rstn_i) begin
         ifu_exp_q.delete();
         lsu_exp_q.delete();
      end else begin
         check("ifu_rvalid", {127'd0, ifu_rvalid_o}, {127'd0, ifu_exp_q.size() > 0});
         if (ifu_exp_q.size() > 0) begin
            mon_e = ifu_exp_q.pop_front();
            check("ifu_rdata", ifu_rdata_o, mon_e);
         end else begin
            check("ifu_rdata_idle", ifu_rdata_o, 0);
         end
         check("lsu_rvalid", {127'd0, lsu_rvalid_o}, {127'd0, lsu_exp_q.size() > 0});
         if (lsu_exp_q.size() > 0) begin
            mon_e = lsu_exp_q.pop_front();
            check("lsu_rdata", lsu_rdata_o, mon_e);
         end else begin
            check("lsu_rdata_idle", lsu_rdata_o, 0);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cycle(input logic ir, input logic [AW-1:0] ia,
                        input logic lr, input logic lw, input logic [3:0] lb,
                        input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        input logic eig, input logic elg,
                        input logic [DW-1:0] eresp, input bit push, input string tag);
      ifu_req_i   = ir;
      ifu_addr_i  = ia;
      lsu_req_i   = lr;
      lsu_we_i    = lw;
      lsu_be_i    = lb;
      lsu_addr_i  = la;
      lsu_wdata_i = ld;
      @(negedge clk_i);
      check({tag, "_ifu_gnt"}, ifu_gnt_o, eig);
      check({tag, "_lsu_gnt"}, lsu_gnt_o, elg);
      check({tag, "_ram_en"},  ram_en_o, eig | elg);
      if (elg)      check({tag, "_ram_addr"}, ram_addr_o, la[RAW+1:2]);
      else if (eig) check({tag, "_ram_addr"}, ram_addr_o, ia[RAW+1:2]);
      check({tag, "_ram_we"},    ram_we_o, (elg && lw) ? lb : 4'h0);
      check({tag, "_ram_wdata"}, ram_wdata_o, elg ? ld : 32'h0);
      if (push && eig) ifu_exp_q.push_back(eresp);
      if (push && elg) lsu_exp_q.push_back(eresp);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
   endtask

   function automatic logic [127:0] all_outputs();
      return {13'd0, ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, lsu_gnt_o, lsu_rvalid_o,
              lsu_rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rstn_i      = 1'b0;
      ifu_req_i   = 1'b1;
      ifu_addr_i  = 32'h8;
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b1;
      lsu_be_i    = 4'hF;
      lsu_addr_i  = 32'h10;
      lsu_wdata_i = 32'hFFFF_FFFF;
      #2;
      check("reset_outputs", all_outputs(), 0);
      ifu_req_i = 1'b0;
      lsu_req_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1'b1;

      // single fetch
      cycle(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0093, 1, "fetch");

      // write, partial write, read back
      cycle(0, 0, 1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, 1, 32'h0, 1, "wr_full");
      cycle(0, 0, 1, 1, 4'h1, 32'h10, 32'h0000_00AA, 0, 1, 32'h0, 1, "wr_byte");
      cycle(0, 0, 1, 0, 4'hF, 32'h10, 32'h0,         0, 1, 32'hDEAD_BEAA, 1, "rd");

      // conflict: LSU first, IFU once LSU drops
      cycle(1, 32'h20, 1, 0, 4'hF, 32'h10, 0, 0, 1, 32'hDEAD_BEAA, 1, "conf_lsu");
      cycle(1, 32'h20, 0, 0, 4'hF, 32'h10, 0, 1, 0, 32'h1234_5678, 1, "conf_ifu");

      // starvation bound: L L L L I L L L L I
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 9)
            cycle(1, 32'h8, 1, 0, 4'hF, 32'h10, 0, 1, 0, 32'h0050_0093, 1, "starve");
         else
            cycle(1, 32'h8, 1, 0, 4'hF, 32'h10, 0, 0, 1, 32'hDEAD_BEAA, 1, "starve");
      end
      idle(1, "drain");

      // reset in the cycle after an IFU grant discards the response
      cycle(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, "rst_fetch");
      check("rst_pending_rvalid", ifu_rvalid_o, 1);
      rstn_i = 1'b0;
      #1;
      check("rst_mid_outputs", all_outputs(), 0);
      ifu_req_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1'b1;

      // idle: no RAM activity and no responses
      idle(5, "idle");

      check("ifu_q_drained", ifu_exp_q.size(), 0);
      check("lsu_q_drained", lsu_exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
